// File: rtl/mac_accumulator.sv
// Multiply-accumulate stage: 4x4 products from a Multiplier4Bit array are summed per packet.
// Define MAC_ACCUMULATOR_SATURATE_EN to clamp the sum on overflow instead of wrapping.

module Multiplier4Bit (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   output logic [7:0] p_o
);

   // Each row adds one shifted partial product to the running sum of the rows above it.
   logic [7:0] row_w [0:4];

   assign row_w[0] = 8'd0;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_row
         assign row_w[gi+1] = row_w[gi] + ({4'b0000, a_i & {4{b_i[gi]}}} << gi);
      end
   endgenerate

   assign p_o = row_w[4];

endmodule

module mac_accumulator #(
   parameter int ACC_WIDTH = 16,
   parameter int MAX_TERMS = 16,
   parameter int CNT_WIDTH = $clog2(MAX_TERMS + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0]           in_a,
   input  logic [3:0]           in_b,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_acc,
   output logic [CNT_WIDTH-1:0] out_count,
   output logic                 out_overflow
);

   generate
      if (ACC_WIDTH < 8) begin : g_bad_acc_width
         $error("mac_accumulator: ACC_WIDTH must be at least 8");
      end
      if (MAX_TERMS < 1) begin : g_bad_max_terms
         $error("mac_accumulator: MAX_TERMS must be at least 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] LAST_TERM = CNT_WIDTH'(MAX_TERMS - 1);

   state_t                 state_q;
   logic                   in_ready_q;
   logic                   out_valid_q;
   logic [7:0]             prod_q;
   logic                   prod_v_q;
   logic                   prod_last_q;
   logic [ACC_WIDTH-1:0]   acc_q;
   logic [CNT_WIDTH-1:0]   count_q;
   logic                   ovf_q;

   logic [7:0]             product_d;
   logic [ACC_WIDTH:0]     sum_d;
   logic [ACC_WIDTH-1:0]   acc_d;
   logic                   ovf_d;
   logic [CNT_WIDTH-1:0]   terms_d;
   logic                   eff_last_d;
   logic                   accept_d;
   logic                   consume_d;

   Multiplier4Bit u_mult (
      .a_i (in_a),
      .b_i (in_b),
      .p_o (product_d)
   );

   always_comb begin
      sum_d = {1'b0, acc_q} + (ACC_WIDTH + 1)'(prod_q);
`ifdef MAC_ACCUMULATOR_SATURATE_EN
      // Once clamped, the sum stays pinned at full scale for the rest of the packet.
      acc_d = (ovf_q || sum_d[ACC_WIDTH]) ? '1 : sum_d[ACC_WIDTH-1:0];
`else
      acc_d = sum_d[ACC_WIDTH-1:0];
`endif
      ovf_d = ovf_q | sum_d[ACC_WIDTH];
      // Beats accepted so far in this packet = accumulated terms plus the one in flight.
      terms_d    = count_q + CNT_WIDTH'(prod_v_q);
      eff_last_d = in_last || (terms_d == LAST_TERM);
      accept_d   = in_valid && in_ready_q;
      consume_d  = out_valid_q && out_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         prod_q      <= '0;
         prod_v_q    <= 1'b0;
         prod_last_q <= 1'b0;
         acc_q       <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
      end else begin
         prod_v_q <= accept_d;
         if (accept_d) begin
            prod_q      <= product_d;
            prod_last_q <= eff_last_d;
         end

         if (prod_v_q) begin
            acc_q   <= acc_d;
            count_q <= count_q + CNT_ONE;
            ovf_q   <= ovf_d;
         end

         case (state_q)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (accept_d) begin
                  if (eff_last_d) begin
                     state_q    <= FLUSH;
                     in_ready_q <= 1'b0;
                  end else begin
                     state_q <= ACCUM;
                  end
               end
            end
            ACCUM: begin
               if (accept_d && eff_last_d) begin
                  state_q    <= FLUSH;
                  in_ready_q <= 1'b0;
               end
            end
            FLUSH: begin
               // Wait for the final product to land in the accumulator before presenting.
               if (!(prod_v_q && prod_last_q)) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (consume_d) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  acc_q       <= '0;
                  count_q     <= '0;
                  ovf_q       <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign out_acc      = acc_q;
   assign out_count    = count_q;
   assign out_overflow = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: a default instance plus a narrow (8-bit, 4-term) instance.

module tb_mac_accumulator;

   logic        clk;
   logic        rst_n;

   logic        in_valid, in_ready, in_last, out_valid, out_ready, out_overflow;
   logic [3:0]  in_a, in_b;
   logic [15:0] out_acc;
   logic [4:0]  out_count;

   logic        s_in_valid, s_in_ready, s_in_last, s_out_valid, s_out_ready, s_out_overflow;
   logic [3:0]  s_in_a, s_in_b;
   logic [7:0]  s_out_acc;
   logic [2:0]  s_out_count;

   int n_assert = 0;
   int n_fail   = 0;

`ifdef MAC_ACCUMULATOR_SATURATE_EN
   localparam int OVF_SUM = 255;
`else
   localparam int OVF_SUM = 194;
`endif

   mac_accumulator dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_last      (in_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_acc      (out_acc),
      .out_count    (out_count),
      .out_overflow (out_overflow)
   );

   mac_accumulator #(.ACC_WIDTH(8), .MAX_TERMS(4)) dut_s (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (s_in_valid),
      .in_ready     (s_in_ready),
      .in_a         (s_in_a),
      .in_b         (s_in_b),
      .in_last      (s_in_last),
      .out_valid    (s_out_valid),
      .out_ready    (s_out_ready),
      .out_acc      (s_out_acc),
      .out_count    (s_out_count),
      .out_overflow (s_out_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
      $display("check %-22s observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic beat(input logic [3:0] a, input logic [3:0] b, input logic last);
      in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
   endtask

   task automatic s_beat(input logic [3:0] a, input logic [3:0] b, input logic last);
      s_in_valid = 1'b1; s_in_a = a; s_in_b = b; s_in_last = last;
   endtask

   task automatic idle();
      in_valid = 1'b0; in_a = 4'hx; in_b = 4'hx; in_last = 1'bx;
   endtask

   task automatic s_idle();
      s_in_valid = 1'b0; s_in_a = 4'hx; s_in_b = 4'hx; s_in_last = 1'bx;
   endtask

   initial begin
      int accepted;
      int results;
      int cyc;

      rst_n = 1'b0;
      out_ready = 1'b0;
      s_out_ready = 1'b0;
      idle();
      s_idle();
      repeat (2) tick();

      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_acc", out_acc, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_out_overflow", out_overflow, 0);
      chk("rst_s_in_ready", s_in_ready, 0);

      rst_n = 1'b1;
      tick();
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_s_in_ready", s_in_ready, 1);

      // Three back-to-back beats, consumer always ready.
      out_ready = 1'b1;
      beat(3, 5, 0);   tick();
      beat(15, 15, 0); tick();
      beat(2, 7, 1);   tick();
      idle();
      chk("t1_valid_e0", out_valid, 0);
      chk("t1_in_ready_flush", in_ready, 0);
      tick();
      chk("t1_valid_e1", out_valid, 0);
      tick();
      chk("t1_valid_e2", out_valid, 1);
      chk("t1_acc", out_acc, 254);
      chk("t1_count", out_count, 3);
      chk("t1_overflow", out_overflow, 0);
      tick();
      chk("t1_valid_after", out_valid, 0);
      chk("t1_in_ready_after", in_ready, 1);

      // Single beat with a stalled consumer; extra beats offered meanwhile must be ignored.
      out_ready = 1'b0;
      beat(15, 15, 1); tick();
      beat(9, 9, 1);
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         chk("t2_valid_hold", out_valid, 1);
         chk("t2_acc_hold", out_acc, 225);
         chk("t2_count_hold", out_count, 1);
         chk("t2_in_ready_hold", in_ready, 0);
         if (i < 4) tick();
      end
      idle();
      out_ready = 1'b1;
      tick();
      chk("t2_valid_consumed", out_valid, 0);
      tick();
      chk("t2_single_consume", out_valid, 0);
      chk("t2_in_ready_after", in_ready, 1);

      // Narrow instance: 8-bit accumulator overflow.
      s_out_ready = 1'b1;
      s_beat(15, 15, 0); tick();
      s_beat(15, 15, 1); tick();
      s_idle();
      tick(); tick();
      chk("t3_valid", s_out_valid, 1);
      chk("t3_acc", s_out_acc, OVF_SUM);
      chk("t3_overflow", s_out_overflow, 1);
      chk("t3_count", s_out_count, 2);
      tick();
      chk("t3_valid_after", s_out_valid, 0);
      chk("t3_overflow_clear", s_out_overflow, 0);

      // Forced termination at MAX_TERMS=4 with six unterminated beats.
      accepted = 0;
      results = 0;
      cyc = 0;
      s_beat(1, 1, 0);
      while (accepted < 6 && cyc < 40) begin
         if (s_out_valid) begin
            results++;
            chk("t4_first_acc", s_out_acc, 4);
            chk("t4_first_count", s_out_count, 4);
         end
         if (s_in_ready) accepted++;
         tick();
         cyc++;
      end
      s_idle();
      chk("t4_accepted", accepted, 6);
      chk("t4_results", results, 1);
      chk("t4_in_ready_open", s_in_ready, 1);
      s_beat(1, 1, 1); tick();
      s_idle();
      tick(); tick();
      chk("t4_second_valid", s_out_valid, 1);
      chk("t4_second_acc", s_out_acc, 3);
      chk("t4_second_count", s_out_count, 3);
      tick();

      // Gapped beats within one packet.
      beat(2, 2, 0); tick();
      idle();        tick();
      beat(0, 9, 0); tick();
      idle();        tick();
      beat(4, 3, 1); tick();
      idle();
      tick();
      chk("t5_valid_e1", out_valid, 0);
      tick();
      chk("t5_valid", out_valid, 1);
      chk("t5_acc", out_acc, 16);
      chk("t5_count", out_count, 3);
      tick();

      // Reset mid-packet discards the partial sum.
      beat(5, 5, 0); tick();
      beat(7, 7, 0); tick();
      idle();
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_in_ready", in_ready, 0);
      chk("t6_rst_valid", out_valid, 0);
      chk("t6_rst_acc", out_acc, 0);
      chk("t6_rst_count", out_count, 0);
      chk("t6_rst_overflow", out_overflow, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("t6_in_ready", in_ready, 1);
      beat(1, 2, 1); tick();
      idle();
      tick(); tick();
      chk("t6_valid", out_valid, 1);
      chk("t6_acc", out_acc, 2);
      chk("t6_count", out_count, 1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
